tis_timer_sequencer: RTL and testbench



---
 rtl/tis_timer_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_tis_timer_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_timer_sequencer.sv
// Avalon-MM master that sequences every access to the 16-bit interval timer:
// period load, start/stop, timeout acknowledge with tick generation, and 32-bit snapshots.
module tis_timer_sequencer #(
    parameter logic [15:0] CTRL_START = 16'h0007,
    parameter logic [15:0] CTRL_STOP  = 16'h0008,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [31:0]      cfg_period,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [31:0]      snap_value,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             running,
    output logic             busy,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
);

    typedef enum logic [3:0] {
        S_HOME,
        S_CFG_L,
        S_CFG_H,
        S_START,
        S_STOP,
        S_ACK,
        S_GUARD,
        S_SNAP_W,
        S_SNAP_RL,
        S_SNAP_RH,
        S_SNAP_CAP
    } state_t;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_CONTROL = 3'd1;
    localparam logic [2:0] A_PERIODL = 3'd2;
    localparam logic [2:0] A_PERIODH = 3'd3;
    localparam logic [2:0] A_SNAPL   = 3'd4;
    localparam logic [2:0] A_SNAPH   = 3'd5;

    state_t             state_q, state_d;
    logic               start_pend_q, start_pend_d;
    logic               stop_pend_q, stop_pend_d;
    logic               snap_pend_q, snap_pend_d;
    logic               running_q, running_d;
    logic [31:0]        period_q, period_d;
    logic               tick_q, tick_d;
    logic [CNT_W-1:0]   tick_count_q, tick_count_d;
    logic [31:0]        snap_q, snap_d;
    logic               snap_valid_q, snap_valid_d;
    logic [2:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wr_n_q, wr_n_d;
    logic [15:0]        wdata_q, wdata_d;

    logic start_eff, stop_eff, snap_eff, cfg_accept;

    // Pulses seen this cycle act like already-pending flags; a same-cycle stop cancels any start.
    assign stop_eff   = stop_pend_q | stop;
    assign start_eff  = ~stop & (start_pend_q | start);
    assign snap_eff   = snap_pend_q | snap_req;
    assign cfg_ready  = (state_q == S_HOME) & ~tmr_irq & ~stop_eff;
    assign cfg_accept = cfg_valid & cfg_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HOME: begin
                if (tmr_irq)         state_d = S_ACK;
                else if (stop_eff)   state_d = S_STOP;
                else if (cfg_accept) state_d = S_CFG_L;
                else if (start_eff)  state_d = S_START;
                else if (snap_eff)   state_d = S_SNAP_W;
            end
            S_CFG_L:    state_d = S_CFG_H;
            // The period write halts the timer, so a running timer is restarted.
            S_CFG_H:    state_d = running_q ? S_START : S_HOME;
            S_START:    state_d = S_HOME;
            S_STOP:     state_d = S_HOME;
            S_ACK:      state_d = S_GUARD;
            S_GUARD:    state_d = S_HOME;
            S_SNAP_W:   state_d = S_SNAP_RL;
            S_SNAP_RL:  state_d = S_SNAP_RH;
            S_SNAP_RH:  state_d = S_SNAP_CAP;
            S_SNAP_CAP: state_d = S_HOME;
            default:    state_d = S_HOME;
        endcase
    end

    // Bus and pulse registers are loaded from the next state so each bus cycle
    // lines up with the state that owns it.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        start_pend_d = start_eff;
        stop_pend_d  = stop_eff;
        snap_pend_d  = snap_eff;
        running_d    = running_q;
        period_d     = period_q;
        tick_d       = 1'b0;
        tick_count_d = tick_count_q;
        snap_d       = snap_q;
        snap_valid_d = 1'b0;
        addr_d       = 3'd0;
        cs_d         = 1'b0;
        wr_n_d       = 1'b1;
        wdata_d      = 16'h0000;

        if (cfg_accept) period_d = cfg_period;

        // Slave read data lags the address by one clock.
        if (state_q == S_SNAP_RH) snap_d[15:0] = tmr_readdata;
        if (state_q == S_SNAP_CAP) begin
            snap_d[31:16] = tmr_readdata;
            snap_valid_d  = 1'b1;
            snap_pend_d   = snap_req;
        end

        unique case (state_d)
            S_CFG_L: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERIODL; wdata_d = period_d[15:0];
            end
            S_CFG_H: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERIODH; wdata_d = period_q[31:16];
            end
            S_START: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL; wdata_d = CTRL_START;
                running_d    = 1'b1;
                start_pend_d = 1'b0;
            end
            S_STOP: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL; wdata_d = CTRL_STOP;
                running_d   = 1'b0;
                stop_pend_d = 1'b0;
            end
            S_ACK: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS;
                if (running_q) begin
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + CNT_W'(1);
                end
            end
            S_SNAP_W: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_SNAPL;
            end
            S_SNAP_RL: begin
                cs_d = 1'b1; addr_d = A_SNAPL;
            end
            S_SNAP_RH: begin
                cs_d = 1'b1; addr_d = A_SNAPH;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_HOME;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            running_q    <= 1'b0;
            period_q     <= 32'h0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            snap_q       <= 32'h0;
            snap_valid_q <= 1'b0;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            wdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            running_q    <= running_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy           = (state_q != S_HOME);
    assign running        = running_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign snap_value     = snap_q;
    assign snap_valid     = snap_valid_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wr_n_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_tis_timer_sequencer.sv
// Bench for tis_timer_sequencer: table of single operations plus hand-written
// multi-cycle sequences, with bus/tick/snapshot events checked against a scoreboard queue.
module tb_tis_timer_sequencer;

    // Narrow tick counter so the wrap-around is reached in a few hundred timeouts.
    localparam int TB_CNT_W = 8;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_TICK = 2'd2;
    localparam logic [1:0] EV_SNAP = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic                start;
        logic                stop;
        logic                cfg;
        logic                irq;
        logic [31:0]         period;
        logic                exp_running;
        logic [TB_CNT_W-1:0] exp_count;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cfg_valid = 1'b0;
    logic [31:0]         cfg_period = 32'h0;
    logic                cfg_ready;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                snap_req = 1'b0;
    logic                snap_valid;
    logic [31:0]         snap_value;
    logic                tick;
    logic [TB_CNT_W-1:0] tick_count;
    logic                running;
    logic                busy;
    logic [2:0]          tmr_address;
    logic                tmr_chipselect;
    logic                tmr_write_n;
    logic [15:0]         tmr_writedata;
    logic [15:0]         tmr_readdata = 16'h0;
    logic                tmr_irq = 1'b0;

    ev_t                 sb_q[$];
    int                  n_cmp = 0;
    int                  n_fail = 0;
    logic                m_running = 1'b0;
    logic [TB_CNT_W-1:0] m_count = '0;

    tis_timer_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_period     (cfg_period),
        .cfg_ready      (cfg_ready),
        .start          (start),
        .stop           (stop),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .running        (running),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    // Timer slave read port: registered, snapshot halves 0x1234 / 0xABCD.
    always @(posedge clk) begin
        if (tmr_chipselect && tmr_write_n)
            tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                            (tmr_address == 3'd5) ? 16'hABCD : 16'h0000;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] kind, input logic [2:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    task automatic sb_observe(input ev_t ev);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected event: got 0x%0h expected none", ev);
        end else begin
            e = sb_q.pop_front();
            check("event", ev, e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (snap_valid) sb_observe(mk(EV_SNAP, 3'd0, snap_value));
            if (tmr_chipselect) begin
                if (tmr_write_n) sb_observe(mk(EV_RD, tmr_address, 32'h0));
                else             sb_observe(mk(EV_WR, tmr_address, {16'h0, tmr_writedata}));
            end
            if (tick) sb_observe(mk(EV_TICK, 3'd0, 32'h0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_start();
        sb_q.push_back(mk(EV_WR, 3'd1, 32'h0007));
        m_running = 1'b1;
    endtask

    task automatic exp_stop();
        sb_q.push_back(mk(EV_WR, 3'd1, 32'h0008));
        m_running = 1'b0;
    endtask

    task automatic exp_cfg(input logic [31:0] p);
        sb_q.push_back(mk(EV_WR, 3'd2, {16'h0, p[15:0]}));
        sb_q.push_back(mk(EV_WR, 3'd3, {16'h0, p[31:16]}));
        if (m_running) sb_q.push_back(mk(EV_WR, 3'd1, 32'h0007));
    endtask

    task automatic exp_ack();
        sb_q.push_back(mk(EV_WR, 3'd0, 32'h0));
        if (m_running) begin
            sb_q.push_back(mk(EV_TICK, 3'd0, 32'h0));
            m_count = m_count + 1'b1;
        end
    endtask

    // Irq stays high through GUARD and into the first HOME edge, then drops.
    task automatic irq_finish(input logic exp_tick);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
                seen = 1'b1;
                break;
            end
        end
        check("irq ack write seen", {63'h0, seen}, 64'h1);
        if (seen) check("tick in ack cycle", {63'h0, tick}, {63'h0, exp_tick});
        step();
        step();
        tmr_irq = 1'b0;
    endtask

    task automatic do_irq();
        logic exp_tick;
        exp_tick = m_running;
        exp_ack();
        tmr_irq = 1'b1;
        irq_finish(exp_tick);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && !busy) break;
            step();
        end
        check({name, " drained"}, {63'h0, (sb_q.size() == 0 && !busy)}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{start:0, stop:0, cfg:0, irq:1, period:32'h0,         exp_running:0, exp_count:0};
        vecs[1]  = '{start:1, stop:0, cfg:0, irq:0, period:32'h0,         exp_running:1, exp_count:0};
        vecs[2]  = '{start:0, stop:0, cfg:0, irq:1, period:32'h0,         exp_running:1, exp_count:1};
        vecs[3]  = '{start:0, stop:0, cfg:1, irq:0, period:32'h0001_86A0, exp_running:1, exp_count:1};
        vecs[4]  = '{start:0, stop:0, cfg:0, irq:1, period:32'h0,         exp_running:1, exp_count:2};
        vecs[5]  = '{start:0, stop:1, cfg:0, irq:0, period:32'h0,         exp_running:0, exp_count:2};
        vecs[6]  = '{start:0, stop:0, cfg:1, irq:0, period:32'hDEAD_BEEF, exp_running:0, exp_count:2};
        vecs[7]  = '{start:0, stop:0, cfg:0, irq:1, period:32'h0,         exp_running:0, exp_count:2};
        vecs[8]  = '{start:1, stop:1, cfg:0, irq:0, period:32'h0,         exp_running:0, exp_count:2};
        vecs[9]  = '{start:1, stop:0, cfg:0, irq:0, period:32'h0,         exp_running:1, exp_count:2};
        vecs[10] = '{start:1, stop:0, cfg:0, irq:0, period:32'h0,         exp_running:1, exp_count:2};

        // Reset state.
        repeat (3) step();
        check("reset bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        check("reset pulses", {tick, snap_valid}, 2'b00);
        check("reset running/busy", {running, busy}, 2'b00);
        check("reset tick_count", tick_count, 0);
        check("reset snap_value", snap_value, 32'h0);
        reset = 1'b0;
        step();
        check("idle cfg_ready", cfg_ready, 1);

        // Start from reset: single control write one cycle later.
        start = 1'b1;
        exp_start();
        step();
        start = 1'b0;
        check("start bus write", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd1, 16'h0007});
        check("start running", running, 1);
        step();
        check("start no further bus", tmr_chipselect, 0);
        stop = 1'b1;
        exp_stop();
        step();
        stop = 1'b0;
        wait_idle("initial stop");

        // Table of single operations.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].irq) begin
                do_irq();
            end else begin
                start = vecs[i].start;
                stop  = vecs[i].stop;
                if (vecs[i].cfg) begin
                    cfg_valid  = 1'b1;
                    cfg_period = vecs[i].period;
                end
                if (vecs[i].stop)       exp_stop();
                else if (vecs[i].start) exp_start();
                if (vecs[i].cfg)        exp_cfg(vecs[i].period);
                step();
                start = 1'b0;
                stop = 1'b0;
                cfg_valid = 1'b0;
            end
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d running", i), running, vecs[i].exp_running);
            check($sformatf("vec%0d tick_count", i), tick_count, vecs[i].exp_count);
        end

        // Period reload while running: L, H, restart on consecutive cycles.
        cfg_valid  = 1'b1;
        cfg_period = 32'h0001_86A0;
        exp_cfg(cfg_period);
        #1;
        check("cfg_ready before accept", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check("cfg L write", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd2, 16'h86A0});
        check("cfg_ready in L", cfg_ready, 0);
        step();
        check("cfg H write", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd3, 16'h0001});
        check("cfg_ready in H", cfg_ready, 0);
        step();
        check("cfg restart write", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd1, 16'h0007});
        check("cfg_ready in restart", cfg_ready, 0);
        wait_idle("cfg running");

        // Snapshot with an irq raised mid-sequence; irq serviced after capture.
        begin
            int n;
            logic exp_tick;
            sb_q.push_back(mk(EV_WR, 3'd4, 32'h0));
            sb_q.push_back(mk(EV_RD, 3'd4, 32'h0));
            sb_q.push_back(mk(EV_RD, 3'd5, 32'h0));
            sb_q.push_back(mk(EV_SNAP, 3'd0, 32'hABCD_1234));
            exp_tick = m_running;
            exp_ack();
            snap_req = 1'b1;
            step();
            snap_req = 1'b0;
            n = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                n++;
                if (n == 1) tmr_irq = 1'b1;
                if (snap_valid) break;
            end
            check("snap_valid latency", n, 4);
            check("snap_value", snap_value, 32'hABCD_1234);
            irq_finish(exp_tick);
            wait_idle("snap");
            check("snap tick_count", tick_count, m_count);
        end

        // Drive the tick counter to all-ones, then wrap it.
        for (int i = 0; i < 300 && m_count != {TB_CNT_W{1'b1}}; i++) do_irq();
        wait_idle("preload");
        check("count at max", tick_count, {TB_CNT_W{1'b1}});
        do_irq();
        wait_idle("wrap");
        check("count wrapped", tick_count, 0);

        // Reset while in SNAP_RL: bus idles at once and no snapshot completes.
        sb_q.push_back(mk(EV_WR, 3'd4, 32'h0));
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        check("in SNAP_RL bus read", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b1, 3'd4});
        #1;
        reset = 1'b1;
        #1;
        check("async reset bus idle", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        check("async reset busy", busy, 0);
        m_running = 1'b0;
        m_count = '0;
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        check("no snapshot after reset", sb_q.size(), 0);
        check("post reset running/count", {running, tick_count}, 0);
        check("post reset snap_value", snap_value, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
